// File: rtl/correlation_stim_gen_if.sv
// Stimulus bus between correlation_stim_gen (master) and the capture/control side (slave).
interface correlation_stim_gen_if #(
  parameter int unsigned WIDTH = 4
);
  logic                 start;
  logic                 ready;
  logic [WIDTH-1:0]     vec;
  logic [2*WIDTH-1:0]   sim_idx;
  logic                 sim_begin;
  logic                 sim_end;
  logic                 busy;
  logic                 done;

  modport master (
    input  start,
    input  ready,
    output vec,
    output sim_idx,
    output sim_begin,
    output sim_end,
    output busy,
    output done
  );

  modport slave (
    output start,
    output ready,
    input  vec,
    input  sim_idx,
    input  sim_begin,
    input  sim_end,
    input  busy,
    input  done
  );
endinterface

// File: rtl/correlation_stim_gen.sv
// Sweeps every ordered pair (i, j) of gate input values, holding i then j for HOLD cycles each,
// with window markers for downstream capture and a ready-driven stall on the last PH_B cycle.
module correlation_stim_gen #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned HOLD  = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  correlation_stim_gen_if.master bus_io
);

  localparam int unsigned CntW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [CntW-1:0] HoldMax = CntW'(HOLD - 1);

  typedef enum logic [1:0] {StIdle, StPhA, StPhB, StFin} state_e;

  state_e               state_q, state_d;
  logic [2*WIDTH-1:0]   idx_q, idx_d;
  logic [CntW-1:0]      hold_q, hold_d;
  logic                 hold_last;

  assign hold_last = (hold_q == HoldMax);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    hold_d  = hold_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          state_d = StPhA;
          idx_d   = '0;
          hold_d  = '0;
        end
      end
      StPhA: begin
        if (hold_last) begin
          state_d = StPhB;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + CntW'(1);
        end
      end
      StPhB: begin
        // hold_cnt saturates at HoldMax while ready is low
        if (hold_last) begin
          if (bus_io.ready) begin
            hold_d = '0;
            if (&idx_q) begin
              state_d = StFin;
            end else begin
              idx_d   = idx_q + (2*WIDTH)'(1);
              state_d = StPhA;
            end
          end
        end else begin
          hold_d = hold_q + CntW'(1);
        end
      end
      StFin: begin
        state_d = StIdle;
        idx_d   = '0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus_io.vec       = '0;
    bus_io.sim_begin = 1'b0;
    bus_io.sim_end   = 1'b0;
    bus_io.busy      = 1'b0;
    bus_io.done      = 1'b0;
    unique case (state_q)
      StIdle: ;
      StPhA: begin
        bus_io.vec       = idx_q[2*WIDTH-1:WIDTH];
        bus_io.sim_begin = hold_last;
        bus_io.busy      = 1'b1;
      end
      StPhB: begin
        bus_io.vec     = idx_q[WIDTH-1:0];
        bus_io.sim_end = hold_last & bus_io.ready;
        bus_io.busy    = 1'b1;
      end
      StFin: begin
        bus_io.busy = 1'b1;
        bus_io.done = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus_io.sim_idx = idx_q;

endmodule

// File: tb/tb_correlation_stim_gen.sv
// Directed bench: WIDTH=2/HOLD=2 sweeps (reset, stall, start-while-busy, mid-sweep reset)
// and a table-driven WIDTH=1/HOLD=1 sweep.
module tb_correlation_stim_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;

  correlation_stim_gen_if #(.WIDTH(2)) if_a ();
  correlation_stim_gen_if #(.WIDTH(1)) if_b ();

  correlation_stim_gen #(.WIDTH(2), .HOLD(2)) dut_a (
    .clk    (clk),
    .rst    (rst_a),
    .bus_io (if_a)
  );

  correlation_stim_gen #(.WIDTH(1), .HOLD(1)) dut_b (
    .clk    (clk),
    .rst    (rst_b),
    .bus_io (if_b)
  );

  // Observation words: {busy, done, sim_begin, sim_end, sim_idx, vec}
  logic [15:0] obs_a, obs_b;
  assign obs_a = {6'b0, if_a.busy, if_a.done, if_a.sim_begin, if_a.sim_end, if_a.sim_idx, if_a.vec};
  assign obs_b = {9'b0, if_b.busy, if_b.done, if_b.sim_begin, if_b.sim_end, if_b.sim_idx, if_b.vec};

  localparam logic [15:0] MaskA    = 16'h03FF;
  localparam logic [15:0] MaskAFin = 16'h03C0;
  localparam logic [15:0] MaskB    = 16'h007F;
  localparam logic [15:0] MaskBFin = 16'h0078;
  localparam logic [15:0] FinA     = 16'h0300;
  localparam logic [15:0] StallA   = {6'b0, 4'b1000, 4'd5, 2'd1};

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        ready;
    logic [15:0] exp;
    logic [15:0] mask;
  } vec_t;

  vec_t tab [11];

  task automatic check(input string name, input int cyc_n, input logic [15:0] act,
                       input logic [15:0] exp, input logic [15:0] mask);
    checks++;
    if ((act & mask) !== (exp & mask)) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h (mask %h)", name, cyc_n, act & mask,
               exp & mask, mask);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Unstalled WIDTH=2/HOLD=2 expectation for window cycle c (1-based)
  function automatic logic [15:0] model_a(input int c);
    int k, w, p;
    logic [3:0] wl;
    logic [1:0] v;
    k  = c - 1;
    w  = k / 4;
    p  = k % 4;
    wl = 4'(w);
    v  = (p < 2) ? wl[3:2] : wl[1:0];
    return {6'b0, 1'b1, 1'b0, (p == 1), (p == 3), wl, v};
  endfunction

  function automatic logic [15:0] mk_b(input logic busy, input logic dn, input logic bg,
                                       input logic en, input logic [1:0] idx, input logic v);
    return {9'b0, busy, dn, bg, en, idx, v};
  endfunction

  initial begin
    tab[0]  = '{1'b1, mk_b(1, 0, 1, 0, 2'd0, 1'b0), MaskB};
    tab[1]  = '{1'b1, mk_b(1, 0, 0, 1, 2'd0, 1'b0), MaskB};
    tab[2]  = '{1'b1, mk_b(1, 0, 1, 0, 2'd1, 1'b0), MaskB};
    tab[3]  = '{1'b1, mk_b(1, 0, 0, 1, 2'd1, 1'b1), MaskB};
    tab[4]  = '{1'b0, mk_b(1, 0, 1, 0, 2'd2, 1'b1), MaskB};  // ready ignored in PH_A
    tab[5]  = '{1'b0, mk_b(1, 0, 0, 0, 2'd2, 1'b0), MaskB};  // stall
    tab[6]  = '{1'b1, mk_b(1, 0, 0, 1, 2'd2, 1'b0), MaskB};
    tab[7]  = '{1'b1, mk_b(1, 0, 1, 0, 2'd3, 1'b1), MaskB};
    tab[8]  = '{1'b1, mk_b(1, 0, 0, 1, 2'd3, 1'b1), MaskB};
    tab[9]  = '{1'b1, mk_b(1, 1, 0, 0, 2'd0, 1'b0), MaskBFin};
    tab[10] = '{1'b1, mk_b(0, 0, 0, 0, 2'd0, 1'b0), MaskB};

    rst_a = 1'b1; if_a.start = 1'b1; if_a.ready = 1'b1;
    rst_b = 1'b1; if_b.start = 1'b0; if_b.ready = 1'b1;

    // Reset held with start high
    for (int n = 0; n < 3; n++) begin
      cyc();
      #1 check("reset", n, obs_a, 16'h0, MaskA);
    end
    rst_a = 1'b0;
    cyc();
    if_a.start = 1'b0;
    check("rst_release_busy", 1, obs_a, 16'h0200, 16'h0200);

    // Full sweep with a start pulse at cycle 10
    for (int c = 1; c <= 64; c++) begin
      if_a.start = (c == 10);
      #1 check("sweep", c, obs_a, model_a(c), MaskA);
      cyc();
    end
    #1 check("sweep_done", 65, obs_a, FinA, MaskAFin);
    cyc();
    #1 check("sweep_idle", 66, obs_a, 16'h0, MaskA);

    // Stall for 3 cycles on the last PH_B cycle of window 5 (cycle 24)
    if_a.start = 1'b1;
    cyc();
    if_a.start = 1'b0;
    for (int c = 1; c <= 67; c++) begin
      logic [15:0] e;
      if_a.ready = !(c >= 24 && c < 27);
      if (c < 24)      e = model_a(c);
      else if (c < 27) e = StallA;
      else             e = model_a(c - 3);
      #1 check("stall", c, obs_a, e, MaskA);
      cyc();
    end
    if_a.ready = 1'b1;
    #1 check("stall_done", 68, obs_a, FinA, MaskAFin);
    cyc();
    #1 check("stall_idle", 69, obs_a, 16'h0, MaskA);

    // Reset in window 7, PH_B (cycle 31), then restart
    if_a.start = 1'b1;
    cyc();
    if_a.start = 1'b0;
    for (int c = 1; c <= 31; c++) begin
      #1 check("pre_reset", c, obs_a, model_a(c), MaskA);
      if (c == 31) rst_a = 1'b1;
      cyc();
    end
    #1 check("mid_reset", 0, obs_a, 16'h0, MaskA);
    rst_a = 1'b0;
    if_a.start = 1'b1;
    cyc();
    if_a.start = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      #1 check("restart", c, obs_a, model_a(c), MaskA);
      cyc();
    end

    // WIDTH=1, HOLD=1 table sweep
    rst_b = 1'b0;
    cyc();
    #1 check("b_idle", 0, obs_b, 16'h0, MaskB);
    if_b.start = 1'b1;
    cyc();
    if_b.start = 1'b0;
    for (int e = 0; e < 11; e++) begin
      if_b.ready = tab[e].ready;
      #1 check("hold1", e + 1, obs_b, tab[e].exp, tab[e].mask);
      cyc();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/correlation_stim_gen.md
# correlation_stim_gen

Clocked stimulus sequencer that drives the input vector of a masked-gate correlation module (`a`, `b`, `r1`, `r2`) through every ordered pair of input values. For each pair it applies an initial vector, then a final vector, and marks the boundaries of each simulation window. Downstream power and toggle capture uses these markers to align its measurements. The block sits directly upstream of the gate-under-test and replaces the nested software loops with a synthesizable, stallable sequence.

## Interface
Parameters:
- `WIDTH`, 4: number of gate inputs driven. `vec` maps MSB-first onto {a, b, r1, r2}.
- `HOLD`, 5: cycles each vector is held per phase. Must be ≥1.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begins a full sweep. Sampled only in IDLE.
- `ready`  in  1  downstream capture can accept the end of a window.
- `vec`  out  WIDTH  stimulus vector to the gate-under-test.
- `sim_idx`  out  2*WIDTH  current simulation number, {i, j}.
- `sim_begin`  out  1  one-cycle pulse marking the last cycle of the initial phase.
- `sim_end`  out  1  one-cycle pulse marking the accepted last cycle of the final phase.
- `busy`  out  1  a sweep is in progress.
- `done`  out  1  one-cycle pulse after the final window completes.

## Operation
- States:
  - IDLE: wait for `start`.
  - PH_A: drive `vec = i`.
  - PH_B: drive `vec = j`.
  - FIN: one-cycle completion state.
- Counters:
  - `i` and `j`, each WIDTH bits. `j` is the inner loop, `i` the outer loop.
  - `hold_cnt`, sized for `HOLD`.
- IDLE -> PH_A when `start` = 1. On entry, `i = j = 0` and `hold_cnt = 0`.
- PH_A:
  - `vec = i`; `hold_cnt` increments each cycle.
  - In the cycle where `hold_cnt == HOLD-1`: assert `sim_begin`, then go to PH_B with `hold_cnt = 0`.
- PH_B:
  - `vec = j`; `hold_cnt` increments each cycle, saturating at `HOLD-1`.
  - While `hold_cnt == HOLD-1` and `ready = 0`: stall. `vec` and `sim_idx` hold and no pulse is asserted.
  - When `hold_cnt == HOLD-1` and `ready = 1`: assert `sim_end`.
    - If `{i, j}` is all ones, go to FIN.
    - Otherwise increment `{i, j}` as one 2*WIDTH counter (j wraps to 0 and carries into i), then go to PH_A with `hold_cnt = 0`.
- `ready` is ignored everywhere except the last PH_B cycle.
- FIN: `done = 1` for one cycle, then IDLE.
- `sim_idx` always equals `{i, j}`.
- `busy = 1` in PH_A, PH_B and FIN.
- `start` while `busy` is ignored; there is no restart or queueing.
- Reset values (also the IDLE values): `vec = 0`, `sim_idx = 0`, `sim_begin = 0`, `sim_end = 0`, `busy = 0`, `done = 0`, state IDLE.
- Reset mid-sweep aborts immediately; outputs take reset values on the next edge.
- Total windows per sweep: 2^(2*WIDTH), which is 256 for WIDTH=4.

## Timing
- `start` high at edge t -> first PH_A cycle at t+1, with `vec = 0` and `busy = 1`.
- Unstalled window: exactly 2*HOLD cycles.
  - `sim_begin` in cycle HOLD of the window.
  - `sim_end` in cycle 2*HOLD.
- Next window's PH_A starts the cycle after `sim_end`; there are no gap cycles.
- Full unstalled sweep: 2*HOLD*2^(2*WIDTH) cycles in PH_A/PH_B, plus 1 FIN cycle.
- Each stall cycle (`ready = 0` on the final PH_B cycle) adds exactly one cycle.
- HOLD=1:
  - `sim_begin` is asserted in the only PH_A cycle.
  - `sim_end` is asserted in the only PH_B cycle.
  - Windows alternate PH_A/PH_B every cycle.
- `sim_begin` and `sim_end` are never asserted in the same cycle.
- `done` is never asserted together with `sim_end`; it follows `sim_end` by one cycle.

## Test plan
- Reset: hold `rst` 3 cycles with `start = 1` -> all outputs 0 and state IDLE. Release `rst` with `start = 1` -> `busy` rises on the next edge.
- Full sweep, WIDTH=2, HOLD=2, `ready = 1`:
  - 16 windows over 64 cycles.
  - `vec` sequence starts 0,0,0,0,0,0,1,1,… (pairs (0,0), (0,1), …).
  - `sim_idx` runs 0..15.
  - 16 `sim_begin` and 16 `sim_end` pulses.
  - `done` at cycle 65, then `busy = 0` and `vec = 0`.
- Stall, WIDTH=2, HOLD=2: hold `ready = 0` for 3 cycles at the end of window 5 -> `vec = 1` and `sim_idx = 5` held; `sim_end` fires once, on the cycle `ready` returns to 1; sweep finishes 3 cycles late.
- Start while busy: pulse `start` at cycle 10 -> no effect on sequence or timing.
- Reset mid-sweep: assert `rst` during window 7, PH_B -> next cycle all outputs 0 and state IDLE. A new `start` restarts from `sim_idx = 0`.
- HOLD=1, WIDTH=1: 4 windows, `vec` = 0,0,0,1,1,0,1,1 on consecutive cycles, `sim_begin` and `sim_end` alternating, `done` at cycle 9.
